clock_ratio_meter: RTL and testbench

Measures the period of a slow, divided clock in units of the fast reference clock and reports the division ratio. It is the receiving end of `clock_divider`: it recovers `int_div` from `clk_out`, flags ratio changes, and indicates lock and loss of clock. It sits in the fast `clk_in` domain and treats the measured clock as an asynchronous data input.

---
 rtl/clock_ratio_meter.sv | 127 ++++++++++++
 tb/tb_clock_ratio_meter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_meter.sv
// Measures the period of clk_meas in clk_in cycles and reports it as a ratio.
// Also flags ratio changes and reports lock and loss of clk_meas.
module clock_ratio_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] ratio,
  output logic             ratio_valid,
  output logic             ratio_changed,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_WAIT_FIRST = 2'd0;
  localparam logic [1:0] S_MEASURE    = 2'd1;
  localparam logic [1:0] S_TIMEOUT    = 2'd2;

  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_edge;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ratio;
  logic [MW-1:0]    r_match;
  logic             r_first;
  logic             r_valid;
  logic             r_changed;
  logic             r_locked;
  logic             r_timeout;

  // Flops reset to 1 so a clk_meas already high at release is not seen as an edge.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_meas};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // ratio_valid is a one-cycle strobe with no ready: the consumer must take ratio
  // in the cycle ratio_valid is high; ratio_changed only ever rises alongside it.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      r_state   <= S_WAIT_FIRST;
      r_cnt     <= '0;
      r_ratio   <= '0;
      r_match   <= '0;
      r_first   <= 1'b1;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      case (r_state)
        S_WAIT_FIRST: begin
          if (w_edge) begin
            r_state <= S_MEASURE;
            r_cnt   <= CNT_ONE;
          end
        end
        S_MEASURE: begin
          // An edge takes priority so a period of exactly TIMEOUT is still captured.
          if (w_edge) begin
            r_ratio <= r_cnt;
            r_valid <= 1'b1;
            r_cnt   <= CNT_ONE;
            r_first <= 1'b0;
            if (r_first) begin
              r_match  <= MATCH_ONE;
              r_locked <= 1'b0;
            end else if (r_cnt == r_ratio) begin
              if (r_match < LOCK_C) r_match <= r_match + MATCH_ONE;
              if (r_match >= LOCK_C - MATCH_ONE) r_locked <= 1'b1;
            end else begin
              r_changed <= 1'b1;
              r_match   <= MATCH_ONE;
              r_locked  <= 1'b0;
            end
          end else if (r_cnt == TIMEOUT_C) begin
            r_state   <= S_TIMEOUT;
            r_timeout <= 1'b1;
            r_locked  <= 1'b0;
            r_match   <= '0;
            r_first   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_TIMEOUT: begin
          if (w_edge) begin
            r_timeout <= 1'b0;
            r_state   <= S_MEASURE;
            r_cnt     <= CNT_ONE;
          end
        end
        default: r_state <= S_WAIT_FIRST;
      endcase
    end
  end

  assign ratio         = r_ratio;
  assign ratio_valid   = r_valid;
  assign ratio_changed = r_changed;
  assign locked        = r_locked;
  assign timeout       = r_timeout;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: clk_meas is generated as an integer
// division of clk_in, so every captured ratio is exact.
module tb_clock_ratio_meter;

  logic        clk_in = 1'b0;
  logic        rstn;
  logic        clk_meas;
  logic [15:0] ratio;
  logic        ratio_valid;
  logic        ratio_changed;
  logic        locked;
  logic        timeout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int fails  = 0;

  int div = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int to_rise_cyc = 0;
  int to_fall_cyc = 0;
  int wide_cnt = 0;
  int orphan_cnt = 0;
  bit to_seen = 0;
  bit prev_v = 0;
  bit prev_to = 0;

  logic [15:0] cap_q[$];
  logic        chg_q[$];
  logic        lck_q[$];

  clock_ratio_meter #(
    .CNT_W(16), .SYNC_STAGES(2), .LOCK_COUNT(4), .TIMEOUT(1024)
  ) dut (
    .clk_in(clk_in), .rstn(rstn), .clk_meas(clk_meas),
    .ratio(ratio), .ratio_valid(ratio_valid), .ratio_changed(ratio_changed),
    .locked(locked), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // clk_meas generator: one period of length div per loop, changes on negedge
  initial begin
    int cur;
    clk_meas = 1'b0;
    forever begin
      if (div == 0) begin
        clk_meas = 1'b0;
        @(negedge clk_in);
      end else begin
        cur = div;
        clk_meas = 1'b1;
        repeat (cur / 2) @(negedge clk_in);
        clk_meas = 1'b0;
        repeat (cur - cur / 2) @(negedge clk_in);
      end
    end
  end

  // monitor: records captures and pulse timing, sampled 1 after the active edge
  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (ratio_valid === 1'b1) begin
      cap_q.push_back(ratio);
      chg_q.push_back(ratio_changed);
      lck_q.push_back(locked);
      last_valid_cyc = cyc;
      if (prev_v) wide_cnt++;
    end
    if (ratio_changed === 1'b1 && ratio_valid !== 1'b1) orphan_cnt++;
    prev_v = (ratio_valid === 1'b1);
    if (timeout === 1'b1) to_seen = 1'b1;
    if (timeout === 1'b1 && !prev_to) to_rise_cyc = cyc;
    if (timeout !== 1'b1 && prev_to) to_fall_cyc = cyc;
    prev_to = (timeout === 1'b1);
  end

  // driver tasks
  task automatic clear_stats();
    cap_q.delete();
    chg_q.delete();
    lck_q.delete();
    to_seen = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cap_q.size() >= n) break;
      @(posedge clk_in);
      #2;
    end
    ok = (cap_q.size() >= n);
  endtask

  // Syncs to a clk_meas rise, loads the new division and clears the records once
  // the capture of the period ending at that rise is in. The queue then holds one
  // more period of the old division followed by periods of the new one.
  task automatic switch_div(input int nd);
    bit last;
    last = clk_meas;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      #1;
      if (clk_meas && !last) break;
      last = clk_meas;
    end
    div = nd;
    repeat (3) @(posedge clk_in);
    #2;
    clear_stats();
  endtask

  // scenarios
  task automatic test_reset();
    rstn = 1'b0;
    div  = 0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (ratio !== 16'd0) begin fails++; $display("FAIL reset_ratio: got %0d want 0", ratio); end
    checks++; if (ratio_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ratio_valid); end
    checks++; if (ratio_changed !== 1'b0) begin fails++; $display("FAIL reset_changed: got %b want 0", ratio_changed); end
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(posedge clk_in);
    #2;
    rstn = 1'b1;
    clear_stats();
  endtask

  task automatic test_div4();
    bit ok;
    div = 4;
    wait_caps(4, 200, ok);
    checks++; if (!ok) begin fails++; $display("FAIL div4_caps: got %0d captures want 4", cap_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_q[i] !== 16'd4) begin fails++; $display("FAIL div4_ratio[%0d]: got %0d want 4", i, cap_q[i]); end
      checks++; if (chg_q[i] !== 1'b0) begin fails++; $display("FAIL div4_changed[%0d]: got %b want 0", i, chg_q[i]); end
      checks++; if (lck_q[i] !== (i == 3)) begin fails++; $display("FAIL div4_locked[%0d]: got %b want %0d", i, lck_q[i], (i == 3)); end
    end
  endtask

  task automatic test_div2_switch();
    bit ok;
    logic [15:0] exp_r[5] = '{16'd4, 16'd2, 16'd2, 16'd2, 16'd2};
    logic        exp_c[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        exp_l[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    switch_div(2);
    wait_caps(5, 200, ok);
    checks++; if (!ok) begin fails++; $display("FAIL div2_caps: got %0d captures want 5", cap_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (cap_q[i] !== exp_r[i]) begin fails++; $display("FAIL div2_ratio[%0d]: got %0d want %0d", i, cap_q[i], exp_r[i]); end
      checks++; if (chg_q[i] !== exp_c[i]) begin fails++; $display("FAIL div2_changed[%0d]: got %b want %b", i, chg_q[i], exp_c[i]); end
      checks++; if (lck_q[i] !== exp_l[i]) begin fails++; $display("FAIL div2_locked[%0d]: got %b want %b", i, lck_q[i], exp_l[i]); end
    end
  endtask

  task automatic test_div8_div5();
    bit ok;
    int news[3] = '{8, 5, 8};
    int olds[3] = '{2, 8, 5};
    for (int s = 0; s < 3; s++) begin
      switch_div(news[s]);
      wait_caps(3, 200, ok);
      checks++; if (!ok) begin fails++; $display("FAIL sw%0d_caps: got %0d captures want 3", s, cap_q.size()); end
      checks++; if (cap_q[0] !== 16'(olds[s])) begin fails++; $display("FAIL sw%0d_old: got %0d want %0d", s, cap_q[0], olds[s]); end
      checks++; if (cap_q[1] !== 16'(news[s]) || cap_q[2] !== 16'(news[s])) begin fails++; $display("FAIL sw%0d_new: got %0d,%0d want %0d", s, cap_q[1], cap_q[2], news[s]); end
      checks++; if ({chg_q[0], chg_q[1], chg_q[2]} !== 3'b010) begin fails++; $display("FAIL sw%0d_changed: got %b%b%b want 010", s, chg_q[0], chg_q[1], chg_q[2]); end
    end
    checks++; if (wide_cnt !== 0) begin fails++; $display("FAIL valid_width: got %0d wide pulses want 0", wide_cnt); end
    checks++; if (orphan_cnt !== 0) begin fails++; $display("FAIL changed_alone: got %0d orphan pulses want 0", orphan_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    switch_div(0);
    to_rise_cyc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (timeout === 1'b1) break;
      @(posedge clk_in);
      #2;
    end
    checks++; if (timeout !== 1'b1) begin fails++; $display("FAIL to_rise: got %b want 1", timeout); end
    checks++; if (to_rise_cyc - last_valid_cyc !== 1024) begin fails++; $display("FAIL to_delay: got %0d cycles want 1024", to_rise_cyc - last_valid_cyc); end
    checks++; if (locked !== 1'b0) begin fails++; $display("FAIL to_locked: got %b want 0", locked); end
    checks++; if (ratio !== 16'd8) begin fails++; $display("FAIL to_ratio_hold: got %0d want 8", ratio); end
    repeat (20) @(posedge clk_in);
    #2;
    checks++; if (timeout !== 1'b1) begin fails++; $display("FAIL to_hold: got %b want 1", timeout); end
    clear_stats();
    to_fall_cyc = 0;
    div = 4;
    for (int i = 0; i < 100; i++) begin
      if (timeout === 1'b0) break;
      @(posedge clk_in);
      #2;
    end
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_fall: got %b want 0", timeout); end
    wait_caps(1, 100, ok);
    checks++; if (!ok || cap_q[0] !== 16'd4) begin fails++; $display("FAIL to_resume_ratio: got %0d want 4", cap_q[0]); end
    checks++; if (chg_q[0] !== 1'b0) begin fails++; $display("FAIL to_resume_changed: got %b want 0", chg_q[0]); end
    checks++; if (cap_q.size() == 1 && last_valid_cyc - to_fall_cyc !== 4) begin fails++; $display("FAIL to_resume_delay: got %0d want 4", last_valid_cyc - to_fall_cyc); end
  endtask

  task automatic test_period_boundary();
    bit ok;
    switch_div(1024);
    wait_caps(2, 2500, ok);
    checks++; if (!ok || cap_q[1] !== 16'd1024) begin fails++; $display("FAIL p1024_ratio: got %0d want 1024", cap_q[1]); end
    checks++; if (to_seen !== 1'b0) begin fails++; $display("FAIL p1024_timeout: got %b want 0", to_seen); end
    switch_div(1025);
    for (int i = 0; i < 3000; i++) begin
      if (timeout === 1'b1) break;
      @(posedge clk_in);
      #2;
    end
    checks++; if (timeout !== 1'b1) begin fails++; $display("FAIL p1025_timeout: got %b want 1", timeout); end
    checks++; if (cap_q.size() !== 1 || cap_q[0] !== 16'd1024) begin fails++; $display("FAIL p1025_caps: got %0d captures want 1", cap_q.size()); end
    repeat (2200) @(posedge clk_in);
    #2;
    checks++; if (cap_q.size() !== 1) begin fails++; $display("FAIL p1025_nocap: got %0d captures want 1", cap_q.size()); end
    checks++; if (ratio !== 16'd1024) begin fails++; $display("FAIL p1025_hold: got %0d want 1024", ratio); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit last;
    switch_div(8);
    wait_caps(2, 3000, ok);
    last = clk_meas;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      #1;
      if (clk_meas && !last) break;
      last = clk_meas;
    end
    repeat (2) @(posedge clk_in);
    #2;
    rstn = 1'b0;
    @(posedge clk_in);
    #1;
    checks++; if (ratio !== 16'd0 || ratio_valid !== 1'b0 || ratio_changed !== 1'b0) begin fails++; $display("FAIL rmid_ratio: got %0d/%b/%b want 0/0/0", ratio, ratio_valid, ratio_changed); end
    checks++; if (locked !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL rmid_flags: got %b/%b want 0/0", locked, timeout); end
    checks++; if (clk_meas !== 1'b1) begin fails++; $display("FAIL rmid_meas_high: got %b want 1", clk_meas); end
    @(posedge clk_in);
    #2;
    rstn = 1'b1;
    clear_stats();
    wait_caps(1, 300, ok);
    checks++; if (!ok || cap_q[0] !== 16'd8) begin fails++; $display("FAIL rmid_first: got %0d want 8", cap_q[0]); end
    checks++; if (chg_q[0] !== 1'b0 || lck_q[0] !== 1'b0) begin fails++; $display("FAIL rmid_flags_cap: got %b/%b want 0/0", chg_q[0], lck_q[0]); end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div2_switch();
    test_div8_div5();
    test_timeout();
    test_period_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
